// File: rtl/rs_line_1_to_n.sv
// rs_line_1_to_n
//
// Splits one stream of RS (data, parity) lines into NUM_OUTPUTS lanes in strict
// round-robin, NUM_LINES consecutive lines per lane before moving on. Lane k
// sees exactly the lines the encoder-side N-to-1 reducer took from input k, in
// the same order. A 2-entry buffer keeps upstream ready free of any path from
// the lane readies.
//
// Ports:
//   clk                     clock
//   rst_n                   asynchronous active-low reset
//   src_splt_line_val       upstream line valid
//   src_splt_line_data      upstream line data   [DATA_W]
//   src_splt_line_parity    upstream line parity [PARITY_W]
//   splt_src_line_rdy       upstream ready (registered state only)
//   splt_dst_line_vals      per-lane valid, one-hot on the selected lane
//   splt_dst_line_datas     head data broadcast to all lanes   [NUM_OUTPUTS*DATA_W]
//   splt_dst_line_parities  head parity broadcast to all lanes [NUM_OUTPUTS*PARITY_W]
//   dst_splt_line_rdys      per-lane ready; only the selected lane's is used
//   splt_cur_lane           current destination lane index

module rs_line_1_to_n #(
    parameter  int NUM_OUTPUTS = 32,
    parameter  int DATA_W      = 256,
    parameter  int PARITY_W    = 32,
    parameter  int NUM_LINES   = 1,
    localparam int IDX_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
    localparam int CNT_W       = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            src_splt_line_val,
    input  logic [DATA_W-1:0]               src_splt_line_data,
    input  logic [PARITY_W-1:0]             src_splt_line_parity,
    output logic                            splt_src_line_rdy,
    output logic [NUM_OUTPUTS-1:0]          splt_dst_line_vals,
    output logic [NUM_OUTPUTS*DATA_W-1:0]   splt_dst_line_datas,
    output logic [NUM_OUTPUTS*PARITY_W-1:0] splt_dst_line_parities,
    input  logic [NUM_OUTPUTS-1:0]          dst_splt_line_rdys,
    output logic [IDX_W-1:0]                splt_cur_lane
);

    localparam int LINE_W = DATA_W + PARITY_W;

    logic [LINE_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              out_of_reset;
    logic [IDX_W-1:0]  out_idx;
    logic [CNT_W-1:0]  line_cnt;

    logic              empty;
    logic              full;
    logic              sel_rdy;
    logic              enq;
    logic              deq;
    logic [LINE_W-1:0] head;

    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

    assign splt_src_line_rdy = out_of_reset & ~full;
    assign enq = src_splt_line_val & splt_src_line_rdy;
    assign deq = ~empty & sel_rdy;

    // Ready of the selected lane only; out_idx never exceeds NUM_OUTPUTS-1,
    // so an explicit compare loop avoids indexing past the vector.
    always_comb begin
        sel_rdy = 1'b0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (out_idx == IDX_W'(i)) begin
                sel_rdy = dst_splt_line_rdys[i];
            end
        end
    end

    always_comb begin
        splt_dst_line_vals = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            splt_dst_line_vals[i] = ~empty & (out_idx == IDX_W'(i));
        end
    end

    assign head                   = mem[rd_ptr];
    assign splt_dst_line_datas    = {NUM_OUTPUTS{head[LINE_W-1 -: DATA_W]}};
    assign splt_dst_line_parities = {NUM_OUTPUTS{head[PARITY_W-1:0]}};
    assign splt_cur_lane          = out_idx;

    // Storage needs no reset: an empty count masks whatever it holds.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= {src_splt_line_data, src_splt_line_parity};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq) begin
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Upstream ready is held off for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
        end
    end

    // Lane pointer moves only on dequeue; the wrap is an explicit compare so
    // non-power-of-2 lane counts never visit unused indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx  <= '0;
            line_cnt <= '0;
        end else if (deq) begin
            if (line_cnt == CNT_W'(NUM_LINES - 1)) begin
                line_cnt <= '0;
                if (out_idx == IDX_W'(NUM_OUTPUTS - 1)) begin
                    out_idx <= '0;
                end else begin
                    out_idx <= out_idx + IDX_W'(1);
                end
            end else begin
                line_cnt <= line_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rs_line_1_to_n.sv
// tb_rs_line_1_to_n
//
// Four instances of rs_line_1_to_n with different lane/group configurations run
// side by side on one clock. Each instance has a driver that pushes the expected
// (lane, data, parity) of every accepted line into a queue, and a monitor that
// pops and compares on every lane handshake.
//   cfg0: 4 lanes, 2 lines/group  - streaming, latency, throughput
//   cfg1: 3 lanes, 1 line/group   - non-power-of-2 wrap
//   cfg2: 4 lanes, 1 line/group   - head-of-line backpressure
//   cfg3: 32 lanes, 4 lines/group - reset mid-group, random ready/valid

module tb_rs_line_1_to_n;

    localparam int DW = 16;
    localparam int PW = 8;

    typedef struct {
        int          lane;
        logic [DW-1:0] d;
        logic [PW-1:0] p;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       tests = 0;
    int       fails = 0;
    bit [3:0] done  = '0;

    function automatic logic [PW-1:0] pf(input logic [DW-1:0] d);
        return d[7:0] ^ d[15:8] ^ 8'h3C;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tfail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: required event did not occur (t=%0t)", name, $time);
    endtask

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int NO = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 4 : 32;
        localparam int NL = (g == 3) ? 4 : (g == 0) ? 2 : 1;
        localparam int IW = $clog2(NO);

        logic              rst_n;
        logic              sval;
        logic              srdy;
        logic [DW-1:0]     sdata;
        logic [PW-1:0]     spar;
        logic [NO-1:0]     dvals;
        logic [NO-1:0]     drdys;
        logic [NO*DW-1:0]  ddatas;
        logic [NO*PW-1:0]  dpars;
        logic [IW-1:0]     cur;

        exp_t          q[$];
        int            lane_log[$];
        logic [DW-1:0] data_log[$];
        int            mlane = 0;
        int            mcnt  = 0;
        bit            chk_lat = 1'b0;
        bit            pend = 1'b0;
        int            pl;
        logic [DW-1:0] pd;

        rs_line_1_to_n #(
            .NUM_OUTPUTS (NO),
            .DATA_W      (DW),
            .PARITY_W    (PW),
            .NUM_LINES   (NL)
        ) dut (
            .clk                    (clk),
            .rst_n                  (rst_n),
            .src_splt_line_val      (sval),
            .src_splt_line_data     (sdata),
            .src_splt_line_parity   (spar),
            .splt_src_line_rdy      (srdy),
            .splt_dst_line_vals     (dvals),
            .splt_dst_line_datas    (ddatas),
            .splt_dst_line_parities (dpars),
            .dst_splt_line_rdys     (drdys),
            .splt_cur_lane          (cur)
        );

        always @(negedge clk) begin : mon
            int   nv;
            int   l;
            exp_t e;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                nv = $countones(dvals);
                chk($sformatf("cfg%0d_cur_range", g), cur < NO, 1);
                if (nv > 1) begin
                    tfail($sformatf("cfg%0d_onehot_vals", g));
                end else if (nv == 1) begin
                    l = 0;
                    for (int i = 0; i < NO; i++) if (dvals[i]) l = i;
                    chk($sformatf("cfg%0d_lane_vs_cur", g), l, cur);
                    if (pend) begin
                        chk($sformatf("cfg%0d_hold_lane", g), l, pl);
                        chk($sformatf("cfg%0d_hold_data", g), ddatas[l*DW +: DW], pd);
                    end
                    if (drdys[l]) begin
                        pend = 1'b0;
                        if (q.size() == 0) begin
                            tfail($sformatf("cfg%0d_expected_line_queued", g));
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("cfg%0d_lane", g), l, e.lane);
                            chk($sformatf("cfg%0d_data", g), ddatas[l*DW +: DW], e.d);
                            chk($sformatf("cfg%0d_parity", g), dpars[l*PW +: PW], e.p);
                            if (chk_lat) chk($sformatf("cfg%0d_latency", g), cyc, e.cyc);
                            lane_log.push_back(l);
                            data_log.push_back(ddatas[l*DW +: DW]);
                        end
                    end else begin
                        pend = 1'b1;
                        pl   = l;
                        pd   = ddatas[l*DW +: DW];
                    end
                end else if (pend) begin
                    tfail($sformatf("cfg%0d_val_held_until_accept", g));
                    pend = 1'b0;
                end
            end
        end

        task automatic send(input logic [DW-1:0] d, output int waits);
            exp_t e;
            waits = 0;
            sval  = 1'b1;
            sdata = d;
            spar  = pf(d);
            @(negedge clk);
            while (!srdy && waits < 5000) begin
                waits++;
                @(negedge clk);
            end
            if (!srdy) begin
                tfail($sformatf("cfg%0d_send_accepted", g));
            end else begin
                e.lane = mlane;
                e.d    = d;
                e.p    = pf(d);
                e.cyc  = cyc + 1;
                q.push_back(e);
                if (mcnt == NL - 1) begin
                    mcnt  = 0;
                    mlane = (mlane == NO - 1) ? 0 : mlane + 1;
                end else begin
                    mcnt++;
                end
            end
            @(posedge clk);
            #1;
            sval = 1'b0;
        endtask

        task automatic drain();
            int n;
            n = 0;
            while (q.size() != 0 && n < 5000) begin
                n++;
                @(negedge clk);
            end
            chk($sformatf("cfg%0d_drained", g), q.size(), 0);
            @(posedge clk);
            #1;
        endtask

        task automatic power_on();
            rst_n = 1'b0;
            sval  = 1'b1;
            sdata = '0;
            spar  = '0;
            drdys = '1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk($sformatf("cfg%0d_rst_vals", g), dvals, 0);
                chk($sformatf("cfg%0d_rst_rdy", g), srdy, 0);
                chk($sformatf("cfg%0d_rst_cur", g), cur, 0);
            end
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            sval  = 1'b0;
            @(negedge clk);
            chk($sformatf("cfg%0d_rdy_first_cycle", g), srdy, 0);
            @(negedge clk);
            chk($sformatf("cfg%0d_rdy_second_cycle", g), srdy, 1);
            chk($sformatf("cfg%0d_cur_after_rst", g), cur, 0);
            @(posedge clk);
            #1;
        endtask

        if (g == 0) begin : t0
            initial begin
                int w;
                int el[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
                power_on();
                chk_lat = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    send(16'hA000 + 16'(i), w);
                    chk("cfg0_stream_rdy_waits", w, 0);
                end
                drain();
                chk_lat = 1'b0;
                chk("cfg0_count", lane_log.size(), 10);
                for (int i = 0; i < 10; i++) begin
                    chk("cfg0_seq_lane", lane_log[i], el[i]);
                    chk("cfg0_seq_data", data_log[i], 16'hA000 + 16'(i));
                end
                done[0] = 1'b1;
            end
        end else if (g == 1) begin : t1
            initial begin
                int w;
                int el[7] = '{0, 1, 2, 0, 1, 2, 0};
                power_on();
                for (int i = 0; i < 7; i++) send(16'hB000 + 16'(i), w);
                drain();
                chk("cfg1_count", lane_log.size(), 7);
                for (int i = 0; i < 7; i++) begin
                    chk("cfg1_seq_lane", lane_log[i], el[i]);
                    chk("cfg1_seq_data", data_log[i], 16'hB000 + 16'(i));
                end
                done[1] = 1'b1;
            end
        end else if (g == 2) begin : t2
            initial begin
                int el[6] = '{0, 1, 2, 3, 0, 1};
                power_on();
                drdys = 4'b1101;
                fork
                    begin
                        int w;
                        for (int i = 0; i < 6; i++) send(16'hC000 + 16'(i), w);
                    end
                    begin
                        int n;
                        n = 0;
                        @(negedge clk);
                        while (!dvals[1] && n < 100) begin
                            n++;
                            @(negedge clk);
                        end
                        if (!dvals[1]) tfail("cfg2_lane1_valid");
                        for (int k = 0; k < 5; k++) begin
                            if (k > 0) @(negedge clk);
                            chk("cfg2_bp_vals", dvals, 4'b0010);
                            if (k > 0) chk("cfg2_bp_rdy_low", srdy, 0);
                        end
                        @(posedge clk);
                        #1;
                        drdys = 4'b1111;
                        @(negedge clk);
                        @(negedge clk);
                        chk("cfg2_rdy_after_release", srdy, 1);
                    end
                join
                drain();
                chk("cfg2_count", lane_log.size(), 6);
                for (int i = 0; i < 6; i++) begin
                    chk("cfg2_seq_lane", lane_log[i], el[i]);
                    chk("cfg2_seq_data", data_log[i], 16'hC000 + 16'(i));
                end
                done[2] = 1'b1;
            end
        end else begin : t3
            initial begin
                int w;
                int el[5] = '{0, 0, 0, 0, 1};
                bit rnd;
                power_on();
                for (int i = 0; i < 22; i++) send(16'hD000 + 16'(i), w);
                drain();
                chk("cfg3_pre_count", lane_log.size(), 22);
                chk("cfg3_pre_lane20", lane_log[20], 5);
                chk("cfg3_pre_lane21", lane_log[21], 5);
                drdys = '0;
                send(16'hD016, w);
                send(16'hD017, w);
                @(negedge clk);
                chk("cfg3_full_rdy_low", srdy, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                q.delete();
                lane_log.delete();
                data_log.delete();
                mlane = 0;
                mcnt  = 0;
                @(negedge clk);
                chk("cfg3_midrst_vals", dvals, 0);
                chk("cfg3_midrst_rdy", srdy, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                drdys = '1;
                @(posedge clk);
                #1;
                for (int i = 0; i < 5; i++) send(16'hE000 + 16'(i), w);
                drain();
                chk("cfg3_post_count", lane_log.size(), 5);
                for (int i = 0; i < 5; i++) begin
                    chk("cfg3_post_lane", lane_log[i], el[i]);
                    chk("cfg3_post_data", data_log[i], 16'hE000 + 16'(i));
                end

                lane_log.delete();
                data_log.delete();
                rnd = 1'b1;
                fork
                    begin
                        for (int i = 0; i < 10000; i++) begin
                            if ($urandom_range(0, 3) == 0) begin
                                @(posedge clk);
                                #1;
                            end
                            send(16'(i * 40503 + 7), w);
                        end
                        rnd = 1'b0;
                    end
                    begin
                        while (rnd) begin
                            @(posedge clk);
                            #1;
                            drdys = NO'($urandom() | $urandom());
                        end
                    end
                join
                drdys = '1;
                drain();
                chk("cfg3_rand_count", lane_log.size(), 10000);
                done[3] = 1'b1;
            end
        end
    end

    initial begin
        fork
            wait (done == 4'hF);
            #3000000;
        join_any
        if (done != 4'hF) tfail("global_time_limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs_line_1_to_n.md
Name: rs_line_1_to_n

Overview:
- Inverse of the RS line N-to-1 reduction tree: accepts one stream of (data, parity) lines and distributes them in strict round-robin to NUM_OUTPUTS lanes.
- Each lane receives NUM_LINES consecutive lines before the pointer advances.
- Sits in front of per-lane RS decode/check engines, so that lane k sees exactly the lines the encoder-side reducer took from input k, in the same order.
- A 2-entry input buffer decouples upstream ready from downstream ready.

Parameters:
- NUM_OUTPUTS, 32, number of destination lanes; any value >= 2, not required to be a power of 2.
- DATA_W, 256, line data width in bits.
- PARITY_W, 32, line parity width in bits.
- NUM_LINES, 1, consecutive lines sent to one lane before advancing; >= 1.
- Derived (localparam): IDX_W = max(1, clog2(NUM_OUTPUTS)); CNT_W = max(1, clog2(NUM_LINES)).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_splt_line_val  in  1  upstream line valid
- src_splt_line_data  in  DATA_W  upstream line data
- src_splt_line_parity  in  PARITY_W  upstream line parity
- splt_src_line_rdy  out  1  upstream ready
- splt_dst_line_vals  out  NUM_OUTPUTS  per-lane valid
- splt_dst_line_datas  out  NUM_OUTPUTS x DATA_W  per-lane data
- splt_dst_line_parities  out  NUM_OUTPUTS x PARITY_W  per-lane parity
- dst_splt_line_rdys  in  NUM_OUTPUTS  per-lane ready
- splt_cur_lane  out  IDX_W  current destination lane index (debug/status)

Behaviour:
- Reset: rst_n low asynchronously clears the FIFO (empty), sets out_idx=0 and line_cnt=0, and clears out_of_reset.
  - While rst_n is low: all splt_dst_line_vals=0, splt_src_line_rdy=0, splt_cur_lane=0.
  - out_of_reset sets on the first clk edge after deassertion. splt_src_line_rdy therefore rises 1 cycle after rst_n rises.
  - Reset mid-transfer discards buffered lines. No partial lane group survives; the next line after reset goes to lane 0.
- Input handshake:
  - Enqueue when src_splt_line_val & splt_src_line_rdy.
  - splt_src_line_rdy = out_of_reset & ~full. It is registered-state only, with no combinational path from dst_splt_line_rdys.
  - Enqueue while full is impossible because rdy=0. Simultaneous enq+deq with 1 entry is legal. Simultaneous enq+deq with 2 entries cannot enqueue.
- FIFO: 2 entries, width DATA_W+PARITY_W. Sustains 1 line/cycle when lanes are always ready.
- Latency: a line enqueued at edge T is visible at the lane output in the cycle after T. Minimum 1 cycle; no combinational in-to-out path.
- Output:
  - splt_dst_line_vals[i] = ~empty & (i == out_idx).
  - Data and parity of the FIFO head are broadcast to every lane. Lanes qualify with val.
  - Dequeue when ~empty & dst_splt_line_rdys[out_idx]. Ready of non-selected lanes is ignored.
  - Lane valid, once high, holds with stable data until accepted (no retraction).
- Pointer logic (updates only on dequeue):
  - If line_cnt == NUM_LINES-1: line_cnt<=0 and out_idx<=(out_idx==NUM_OUTPUTS-1)?0:out_idx+1. Otherwise line_cnt<=line_cnt+1.
  - With NUM_LINES=1, out_idx advances on every dequeue.
  - Wrap is explicit compare, never modulo 2^IDX_W.
- splt_cur_lane = out_idx (registered).
- Stall: a stalled selected lane blocks all lanes (head-of-line, by design, to preserve ordering). The FIFO fills to 2 and then upstream rdy drops.
- No other state. No error outputs.

Test Plan:
- Reset: hold rst_n low 3 cycles with src val=1 -> all vals=0 and rdy=0. Rdy=1 exactly 1 cycle after rst_n rises; cur_lane=0.
- Streaming, NUM_OUTPUTS=4, NUM_LINES=2, all lanes ready: send lines D0..D9 back-to-back -> lane0 gets D0,D1; lane1 D2,D3; lane2 D4,D5; lane3 D6,D7; lane0 D8,D9. One line out per cycle after 1-cycle latency; rdy never drops.
- Non-power-of-2 wrap, NUM_OUTPUTS=3, NUM_LINES=1: send 7 lines -> lane sequence 0,1,2,0,1,2,0; cur_lane never reaches 3.
- Backpressure, NUM_OUTPUTS=4, NUM_LINES=1: dst_rdys[1]=0 for 5 cycles while src streams -> lane1 val held with stable data. Lanes 0/2/3 vals=0 even though their rdy=1. After 2 more enqueues, splt_src_line_rdy=0. On release, data order is preserved, no loss or duplication, and rdy returns 1 the cycle after the first dequeue.
- Random ready/valid, NUM_OUTPUTS=32, NUM_LINES=4, 10,000 lines -> a per-lane scoreboard matches the expected round-robin model exactly, and no val is seen on a non-selected lane.
- Reset mid-group, NUM_LINES=4: assert rst_n low after 2 lines delivered to lane 5 with 2 lines buffered -> buffered lines dropped. The first post-reset line arrives on lane 0 and the lane-0 group is a full 4 lines.
